// File: rtl/avg_mon_pkg.sv
// Shared types and constants for the averaged-sample level monitor.
// Holds the FSM state encoding and the debounce counter width.
package avg_mon_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int DEB_CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOW      = 3'd1,
    ARM_HIGH = 3'd2,
    HIGH     = 3'd3,
    ARM_LOW  = 3'd4
  } state_t;

  // The reported level follows the committed side, not the side being armed.
  function automatic logic is_level_high(input state_t s);
    return (s == HIGH) || (s == ARM_LOW);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment coincident
// with clear yields a value of one.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] r_value;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= inc ? WIDTH'(1) : '0;
    end else if (inc && (r_value != MAX_VAL)) begin
      r_value <= r_value + WIDTH'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/avg_level_monitor.sv
// Hysteresis level detector with debounce on the averaged sample stream.
// Optional build macro LEVEL_MON_PEAK_EN adds peak_max/peak_min tracking.
module avg_level_monitor
  import avg_mon_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HI_THR   = 10,
  parameter int LO_THR   = 6,
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr,
  output logic              level_high,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [CNT_W-1:0]  event_count
`ifdef LEVEL_MON_PEAK_EN
  ,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min
`endif
);

  localparam logic [DATA_W-1:0]    HI_T = DATA_W'(HI_THR);
  localparam logic [DATA_W-1:0]    LO_T = DATA_W'(LO_THR);
  localparam logic [DEB_CNT_W-1:0] DEB  = DEB_CNT_W'(DEBOUNCE);

  state_t               r_state;
  logic [DEB_CNT_W-1:0] r_cnt;
  logic                 r_level_high;
  logic                 r_rise;
  logic                 r_fall;

  state_t               w_state_nxt;
  logic [DEB_CNT_W-1:0] w_cnt_nxt;
  logic [DEB_CNT_W-1:0] w_cnt_inc;
  logic                 w_level_nxt;
  logic                 w_rise_nxt;
  logic                 w_fall_nxt;
  logic                 w_hi;
  logic                 w_lo;
  logic [CNT_W-1:0]     w_event_count;

  assign w_hi      = (in_data >= HI_T);
  assign w_lo      = (in_data <= LO_T);
  assign w_cnt_inc = r_cnt + DEB_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_level_high <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_level_high <= w_level_nxt;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
    end
  end

  // Idle cycles fall through with state and debounce count held.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (in_valid) begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = w_hi ? HIGH : LOW;
        end
        LOW: begin
          if (w_hi) begin
            if (DEB == DEB_CNT_W'(1)) begin
              w_state_nxt = HIGH;
            end else begin
              w_state_nxt = ARM_HIGH;
              w_cnt_nxt   = DEB_CNT_W'(1);
            end
          end
        end
        ARM_HIGH: begin
          if (!w_hi) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == DEB) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        HIGH: begin
          if (w_lo) begin
            if (DEB == DEB_CNT_W'(1)) begin
              w_state_nxt = LOW;
            end else begin
              w_state_nxt = ARM_LOW;
              w_cnt_nxt   = DEB_CNT_W'(1);
            end
          end
        end
        ARM_LOW: begin
          if (!w_lo) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == DEB) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Pulses fire only on committed transitions out of LOW/HIGH sides, never from IDLE.
  always_comb begin
    w_level_nxt = is_level_high(w_state_nxt);
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (in_valid) begin
      w_rise_nxt = ((r_state == LOW)  || (r_state == ARM_HIGH)) && (w_state_nxt == HIGH);
      w_fall_nxt = ((r_state == HIGH) || (r_state == ARM_LOW))  && (w_state_nxt == LOW);
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_event_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_rise_nxt),
    .clr   (clr),
    .value (w_event_count)
  );

  assign level_high  = r_level_high;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign event_count = w_event_count;

`ifdef LEVEL_MON_PEAK_EN
  logic [DATA_W-1:0] r_peak_max;
  logic [DATA_W-1:0] r_peak_min;

  // A clear restarts tracking, seeded by any sample accepted on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_peak_max <= '0;
      r_peak_min <= '1;
    end else if (clr) begin
      r_peak_max <= in_valid ? in_data : '0;
      r_peak_min <= in_valid ? in_data : '1;
    end else if (in_valid) begin
      if (in_data > r_peak_max) r_peak_max <= in_data;
      if (in_data < r_peak_min) r_peak_min <= in_data;
    end
  end

  assign peak_max = r_peak_max;
  assign peak_min = r_peak_min;
`endif

endmodule

// File: tb/tb_avg_level_monitor.sv
// Self-checking bench for avg_level_monitor: a sample-history model checked every
// cycle on two instances (CNT_W=8 and CNT_W=2), plus directed literal checks.
module tb_avg_level_monitor;

  localparam int DATA_W   = 6;
  localparam int HI_THR   = 10;
  localparam int LO_THR   = 6;
  localparam int DEBOUNCE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] in_data = '0;

  logic              level_high, rise_pulse, fall_pulse;
  logic [7:0]        event_count;
  logic              level_high_c2, rise_pulse_c2, fall_pulse_c2;
  logic [1:0]        event_count_c2;
`ifdef LEVEL_MON_PEAK_EN
  logic [DATA_W-1:0] peak_max, peak_min, peak_max_c2, peak_min_c2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  avg_level_monitor #(
    .DATA_W(DATA_W), .HI_THR(HI_THR), .LO_THR(LO_THR), .DEBOUNCE(DEBOUNCE), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .level_high(level_high), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .event_count(event_count)
`ifdef LEVEL_MON_PEAK_EN
    , .peak_max(peak_max), .peak_min(peak_min)
`endif
  );

  avg_level_monitor #(
    .DATA_W(DATA_W), .HI_THR(HI_THR), .LO_THR(LO_THR), .DEBOUNCE(DEBOUNCE), .CNT_W(2)
  ) u_dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .level_high(level_high_c2), .rise_pulse(rise_pulse_c2), .fall_pulse(fall_pulse_c2),
    .event_count(event_count_c2)
`ifdef LEVEL_MON_PEAK_EN
    , .peak_max(peak_max_c2), .peak_min(peak_min_c2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: level is decided by the first sample, then flips once DEBOUNCE
  // consecutive accepted samples sit beyond the opposite threshold.
  int m_level;   // -1 = no sample seen since reset
  int m_run;
  int m_rise, m_fall;
  int m_cnt8, m_cnt2;
  int m_pmax, m_pmin;
  bit m_live = 1'b0;
  bit m_qual;

  always @(posedge clk) begin
    m_live = 1'b1;
    m_rise = 0;
    m_fall = 0;
    if (rst) begin
      m_level = -1; m_run = 0; m_cnt8 = 0; m_cnt2 = 0; m_pmax = 0; m_pmin = 63;
    end else begin
      if (in_valid) begin
        if (m_level < 0) begin
          m_level = (int'(in_data) >= HI_THR) ? 1 : 0;
        end else begin
          m_qual = (m_level == 1) ? (int'(in_data) <= LO_THR) : (int'(in_data) >= HI_THR);
          if (m_qual) begin
            m_run++;
            if (m_run == DEBOUNCE) begin
              m_level = 1 - m_level;
              m_run   = 0;
              m_rise  = (m_level == 1) ? 1 : 0;
              m_fall  = (m_level == 0) ? 1 : 0;
            end
          end else begin
            m_run = 0;
          end
        end
      end
      if (clr) begin
        m_cnt8 = m_rise;
        m_cnt2 = m_rise;
      end else if (m_rise == 1) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
      if (clr) begin
        m_pmax = in_valid ? int'(in_data) : 0;
        m_pmin = in_valid ? int'(in_data) : 63;
      end else if (in_valid) begin
        if (int'(in_data) > m_pmax) m_pmax = int'(in_data);
        if (int'(in_data) < m_pmin) m_pmin = int'(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("level_high",     level_high,     (m_level == 1) ? 1 : 0);
      check("rise_pulse",     rise_pulse,     m_rise);
      check("fall_pulse",     fall_pulse,     m_fall);
      check("event_count",    event_count,    m_cnt8);
      check("level_high_c2",  level_high_c2,  (m_level == 1) ? 1 : 0);
      check("rise_pulse_c2",  rise_pulse_c2,  m_rise);
      check("fall_pulse_c2",  fall_pulse_c2,  m_fall);
      check("event_count_c2", event_count_c2, m_cnt2);
`ifdef LEVEL_MON_PEAK_EN
      check("peak_max",    peak_max,    m_pmax);
      check("peak_min",    peak_min,    m_pmin);
      check("peak_max_c2", peak_max_c2, m_pmax);
      check("peak_min_c2", peak_min_c2, m_pmin);
`endif
    end
  end

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic c = 1'b0);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clr      = c;
  endtask

  task automatic idle(input int n = 1);
    repeat (n) drive(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic go_low;
    drive(1'b1, 6'd5); drive(1'b1, 6'd4); drive(1'b1, 6'd3);
  endtask

  task automatic go_high;
    drive(1'b1, 6'd11); drive(1'b1, 6'd12); drive(1'b1, 6'd13);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst level", level_high, 0);
    check("rst rise",  rise_pulse, 0);
    check("rst fall",  fall_pulse, 0);
    check("rst count", event_count, 0);

    // First sample from IDLE goes straight to HIGH, silently
    drive(1'b1, 6'd12); idle();
    check("idle->high level", level_high, 1);
    check("idle->high rise",  rise_pulse, 0);
    check("idle->high count", event_count, 0);

    // Debounced rise, back-to-back samples
    do_reset;
    drive(1'b1, 6'd3); go_high; idle();
    check("rise pulse",  rise_pulse, 1);
    check("rise level",  level_high, 1);
    check("rise count",  event_count, 1);
    idle();
    check("rise pulse width", rise_pulse, 0);

    // Debounced fall
    go_low; idle();
    check("fall pulse", fall_pulse, 1);
    check("fall level", level_high, 0);
    idle();
    check("fall pulse width", fall_pulse, 0);

    // Broken run: 9 sends the arming back to LOW, three fresh 12s needed
    drive(1'b1, 6'd11); drive(1'b1, 6'd9); drive(1'b1, 6'd12); idle();
    check("broken run level", level_high, 0);
    drive(1'b1, 6'd12); idle();
    check("broken run no rise", rise_pulse, 0);
    drive(1'b1, 6'd12); idle();
    check("restarted run rise", rise_pulse, 1);
    check("restarted run count", event_count, 2);

    // ARM_LOW abandoned by a sample above LO_THR
    drive(1'b1, 6'd5); drive(1'b1, 6'd8); idle();
    check("abort fall level", level_high, 1);
    check("abort fall pulse", fall_pulse, 0);
    go_low; idle();

    // Idle gaps do not break a debounce run
    drive(1'b1, 6'd11); idle(5); drive(1'b1, 6'd12); idle(3); drive(1'b1, 6'd13); idle();
    check("gap rise",      rise_pulse, 1);
    check("gap count",     event_count, 3);
    check("gap count c2",  event_count_c2, 3);
    idle();
    check("gap rise width", rise_pulse, 0);

    // Two-bit counter saturates at 3
    go_low; go_high; idle();
    check("sat c8 count", event_count, 4);
    check("sat c2 count", event_count_c2, 3);

    // clr on the same edge as a rise leaves a count of one; FSM untouched
    go_low; drive(1'b1, 6'd11); drive(1'b1, 6'd12); drive(1'b1, 6'd13, 1'b1); idle();
    check("clr+rise count",    event_count, 1);
    check("clr+rise count c2", event_count_c2, 1);
    check("clr+rise pulse",    rise_pulse, 1);
    drive(1'b0, '0, 1'b1); idle();
    check("clr count", event_count, 0);
    check("clr level", level_high, 1);

    // Reset mid-arm discards the partial run
    go_low; drive(1'b1, 6'd11); drive(1'b1, 6'd12);
    do_reset;
    check("mid rst level", level_high, 0);
    check("mid rst rise",  rise_pulse, 0);
    check("mid rst fall",  fall_pulse, 0);
    check("mid rst count", event_count, 0);
    drive(1'b1, 6'd11); idle();
    check("post rst level", level_high, 1);
    check("post rst rise",  rise_pulse, 0);
    check("post rst count", event_count, 0);

`ifdef LEVEL_MON_PEAK_EN
    drive(1'b0, '0, 1'b1); idle();
    check("peak clr max", peak_max, 0);
    check("peak clr min", peak_min, 63);
    drive(1'b1, 6'd7); drive(1'b1, 6'd2); drive(1'b1, 6'd14); idle();
    check("peak max", peak_max, 14);
    check("peak min", peak_min, 2);
    drive(1'b1, 6'd9, 1'b1); idle();
    check("peak clr+sample max", peak_max, 9);
    check("peak clr+sample min", peak_min, 9);
`endif

    // Full-width counter saturation
    go_low; go_high;
    repeat (260) begin
      go_low;
      go_high;
    end
    idle();
    check("sat 255 count", event_count, 255);
    check("sat 255 c2",    event_count_c2, 3);

    // Mixed traffic around both thresholds
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), DATA_W'($urandom_range(0, 15)),
            ($urandom_range(0, 31) == 0));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avg_level_monitor.md
Name: avg_level_monitor

Overview:
Downstream consumer of the 4-sample moving-average stage. Takes the averaged 6-bit sample stream (data plus valid strobe) and applies a hysteresis threshold with debounce. Produces a level flag, one-cycle rise/fall event pulses and a saturating count of rise events for the control/status logic.

Parameters:
DATA_W, 6, width of incoming averaged sample
HI_THR, 10, sample >= HI_THR qualifies toward HIGH
LO_THR, 6, sample <= LO_THR qualifies toward LOW; must satisfy LO_THR < HI_THR
DEBOUNCE, 3, consecutive qualifying valid samples needed to switch level; legal range 1..15
CNT_W, 8, width of the rise-event counter

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_data is a new sample this cycle
in_data  in  DATA_W  averaged sample, unsigned
clr  in  1  synchronous clear of statistics; FSM unaffected
level_high  out  1  current debounced level
rise_pulse  out  1  one-cycle pulse on LOW->HIGH transition
fall_pulse  out  1  one-cycle pulse on HIGH->LOW transition
event_count  out  CNT_W  number of rise events; saturating

Behaviour:
- Reset: state=IDLE, debounce count=0, level_high=0, rise_pulse=0, fall_pulse=0, event_count=0. Reset mid-operation discards any partial debounce.
- Samples are accepted only on cycles with in_valid=1. Cycles with in_valid=0 hold all state; gaps do not break a debounce run.
- FSM states: IDLE, LOW, ARM_HIGH, HIGH, ARM_LOW. All outputs are registered and updated on the same edge as the state.
- IDLE, first accepted sample:
  - >= HI_THR: go to HIGH.
  - otherwise: go to LOW.
  - No pulse and no count increment in either case.
- LOW:
  - Sample >= HI_THR with DEBOUNCE=1: go to HIGH and pulse.
  - Sample >= HI_THR with DEBOUNCE>1: go to ARM_HIGH with cnt=1.
  - Any other sample: stay in LOW.
- ARM_HIGH:
  - Sample >= HI_THR: cnt+1. When cnt+1 == DEBOUNCE, go to HIGH, assert rise_pulse and clear cnt.
  - Sample < HI_THR: return to LOW, cnt=0.
- HIGH and ARM_LOW mirror LOW and ARM_HIGH, using sample <= LO_THR and fall_pulse. In ARM_LOW, a sample > LO_THR returns to HIGH.
- level_high=1 in HIGH and ARM_LOW; 0 otherwise.
- Pulse latency: a pulse is high for exactly the one cycle after the edge that accepted the qualifying DEBOUNCE-th sample.
- Rise and fall pulses are mutually exclusive.
- event_count: +1 on each rise event and saturates at 2^CNT_W-1.
- clr: event_count becomes 0. If a rise event occurs in the same cycle, event_count becomes 1.
- Comparisons are unsigned and use full DATA_W width.
- cnt is 4 bits.

Optional Feature:
LEVEL_MON_PEAK_EN
- Defined:
  - Adds outputs peak_max[DATA_W-1:0] and peak_min[DATA_W-1:0], tracking accepted samples since reset/clr.
  - Reset/clr values: peak_max=0, peak_min=all-ones.
  - clr coincident with an accepted sample loads both peaks with that sample.
- Undefined: the ports and logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package avg_mon_pkg holds:
  - state enum typedef (IDLE, LOW, ARM_HIGH, HIGH, ARM_LOW)
  - DATA_W default constant
  - debounce counter width constant (4)
- One sub-module, sat_counter (parameter width; ports inc, clr, value), used for event_count.
- FSM and comparators stay in the top module.

Test Plan:
- Reset, then in_data=12 valid -> level_high=1 the next cycle; no rise_pulse; event_count=0.
- Reset, then 3; then 11,12,13 (each 1 cycle valid) -> rise_pulse high exactly the cycle after 13 is accepted; event_count=1. Then the run 11,9,12 -> no pulse; state returns to LOW on 9.
- From HIGH: 5,4,3 -> fall_pulse one cycle, level_high=0. Separately, 5,8 -> back to HIGH, no pulse, level_high stays 1.
- From LOW: 11, five idle cycles, 12, three idle cycles, 13 -> single rise_pulse after 13.
- CNT_W=2: four rise events -> event_count stays 3.
- clr coincident with a rise event -> event_count=1.
- Assert rst after two qualifying samples in ARM_HIGH -> all outputs 0, state IDLE. Then 11 -> HIGH directly, no pulse.
- With LEVEL_MON_PEAK_EN: samples 7,2,14 -> peak_max=14, peak_min=2. clr with sample 9 -> both peaks 9.
